// File: rtl/key_schedule_ctrl.sv
// Sequential AES-128 key schedule: accepts a cipher key, expands one round key per clock into
// rk[0..ROUNDS], and serves them on a random-access read port. Optional macro: KEY_SCHED_ZEROIZE_EN.
module key_schedule_ctrl #(
  parameter int BYTE     = 8,
  parameter int WORD     = 32,
  parameter int SENTENCE = 128,
  parameter int ROUNDS   = 10
) (
  input  logic                clk,
  input  logic                rst_n,
`ifdef KEY_SCHED_ZEROIZE_EN
  input  logic                zeroize,
`endif
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [SENTENCE-1:0] cipher_key,
  input  logic [3:0]          rd_addr,
  output logic [SENTENCE-1:0] rd_key,
  output logic                rd_key_valid,
  output logic                busy,
  output logic                keys_valid,
  output logic [1:0]          state_dbg
);

  // Handshake: a key transfers on a rising edge where key_valid && key_ready; the producer
  // holds key_valid and cipher_key stable until then. key_valid is ignored while expanding.

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [3:0]          round;
  logic [3:0]          last_idx;
  logic                have_key;
  logic [SENTENCE-1:0] rk [0:ROUNDS];
  logic [SENTENCE-1:0] prev_key;
  logic [SENTENCE-1:0] next_key;
  logic                accept;
  logic                step;
  logic                zero_now;

`ifdef KEY_SCHED_ZEROIZE_EN
  assign zero_now = zeroize;
`else
  assign zero_now = 1'b0;
`endif

  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] a);
    return {a[BYTE-2:0], 1'b0} ^ (a[BYTE-1] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE-1:0] gf_mul(input logic [BYTE-1:0] a, input logic [BYTE-1:0] b);
    logic [BYTE-1:0] p;
    logic [BYTE-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < BYTE; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the AES affine map.
  function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] a);
    logic [BYTE-1:0] sq;
    logic [BYTE-1:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [WORD-1:0] sub_word(input logic [WORD-1:0] w);
    logic [WORD-1:0] r;
    for (int i = 0; i < WORD / BYTE; i++) r[i*BYTE +: BYTE] = sbox(w[i*BYTE +: BYTE]);
    return r;
  endfunction

  function automatic logic [BYTE-1:0] rcon(input logic [3:0] r);
    logic [BYTE-1:0] c;
    c = 8'h01;
    for (int i = 1; i < 16; i++) begin
      if (4'(i) < r) c = xtime(c);
    end
    return c;
  endfunction

  function automatic logic [SENTENCE-1:0] key_step(input logic [SENTENCE-1:0] round_key,
                                                   input logic [3:0] round_number);
    logic [WORD-1:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = round_key[127:96];
    w1 = round_key[95:64];
    w2 = round_key[63:32];
    w3 = round_key[31:0];
    t  = sub_word({w3[WORD-BYTE-1:0], w3[WORD-1 -: BYTE]})
       ^ {rcon(round_number), {(WORD-BYTE){1'b0}}};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    prev_key = '0;
    for (int k = 0; k < ROUNDS; k++) begin
      if (round == 4'(k + 1)) prev_key = rk[k];
    end
  end

  assign next_key = key_step(prev_key, round);

  always_comb begin
    state_nxt = state;
    key_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE, DONE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          accept    = 1'b1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        busy = 1'b1;
        step = 1'b1;
        if (round == 4'(ROUNDS)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    // Zeroize beats an accept or expansion step on the same edge.
    if (zero_now) begin
      state_nxt = IDLE;
      accept    = 1'b0;
      step      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round      <= 4'd0;
      last_idx   <= 4'd0;
      have_key   <= 1'b0;
      keys_valid <= 1'b0;
      for (int k = 0; k <= ROUNDS; k++) rk[k] <= '0;
    end else begin
      state <= state_nxt;
      if (zero_now) begin
        round      <= 4'd0;
        last_idx   <= 4'd0;
        have_key   <= 1'b0;
        keys_valid <= 1'b0;
        for (int k = 0; k <= ROUNDS; k++) rk[k] <= '0;
      end else if (accept) begin
        rk[0]      <= cipher_key;
        round      <= 4'd1;
        last_idx   <= 4'd0;
        have_key   <= 1'b1;
        keys_valid <= 1'b0;
      end else if (step) begin
        for (int k = 1; k <= ROUNDS; k++) begin
          if (round == 4'(k)) rk[k] <= next_key;
        end
        last_idx <= round;
        if (round == 4'(ROUNDS)) keys_valid <= 1'b1;
        else                     round      <= round + 4'd1;
      end
    end
  end

  // last_idx never exceeds ROUNDS, so out-of-range addresses read as invalid.
  assign rd_key_valid = have_key && (rd_addr <= last_idx);

  always_comb begin
    rd_key = '0;
    for (int k = 0; k <= ROUNDS; k++) begin
      if (rd_key_valid && rd_addr == 4'(k)) rd_key = rk[k];
    end
  end

  assign state_dbg = state;

endmodule
